lift_ctrl: RTL and testbench

//  Car-motion controller downstream of the floor-request FIFO. Pops one 4-bit floor request at a time,

---
 rtl/lift_pkg.sv | 14 +
 rtl/lift_timer.sv | 27 ++
 rtl/lift_ctrl.sv | 125 ++++++++++++
 tb/tb_lift_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and constants for the lift car-motion controller.
//   FLOOR_W : width of a floor number / FIFO request
//   state_e : controller states
package lift_pkg;
  localparam int FLOOR_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    MOVE,
    DOOR
  } state_e;
endpackage

// File: rtl/lift_timer.sv
// Up-counter 0..MAX-1 with clear, enable and terminal-count strobe.
//   clk_i  : clock
//   rst_i  : synchronous reset, active-high
//   clr_i  : force count to 0 (wins over enable, masks terminal count)
//   en_i   : advance count this cycle
//   tc_o   : enabled cycle with count == MAX-1; counter wraps to 0 on it
module lift_timer #(
  parameter int MAX = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] cnt_q;

  // A clear in the terminal cycle must not fire tc: door hold relies on it.
  assign tc_o = en_i && !clr_i && (cnt_q == W'(MAX - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || tc_o) cnt_q <= '0;
    else if (en_i)              cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/lift_ctrl.sv
// Car-motion controller: pops one floor request from the request FIFO, moves
// the car floor-by-floor on a travel timer, opens the door on arrival, repeats.
//   i_clock, i_rst          : clock, synchronous active-high reset
//   i_rd_data, i_fifo_empty : FIFO read data (valid cycle after o_rd_en), empty
//   o_rd_en                 : one-cycle pop strobe
//   i_stop                  : emergency stop, freezes everything while high
//   i_door_hold             : obstruction, restarts door timer while door open
//   o_floor, o_dir_up       : current floor, direction of (last) travel
//   o_moving, o_door_open   : car in motion, door open
//   o_busy, o_req_err       : not idle, out-of-range request discarded pulse
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = 16,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int RESET_FLOOR   = 0
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic [FLOOR_W-1:0] i_rd_data,
  input  logic               i_fifo_empty,
  output logic               o_rd_en,
  input  logic               i_stop,
  input  logic               i_door_hold,
  output logic [FLOOR_W-1:0] o_floor,
  output logic               o_dir_up,
  output logic               o_moving,
  output logic               o_door_open,
  output logic               o_busy,
  output logic               o_req_err
);
  localparam logic [FLOOR_W:0] NF_L = (FLOOR_W + 1)'(NUM_FLOORS);

  state_e             state_q;
  logic [FLOOR_W-1:0] floor_q, target_q, floor_step;
  logic               dir_up_q, moving_q, door_q, busy_q, err_q, rd_en_q;
  logic               trav_en, trav_clr, trav_tc;
  logic               door_en, door_clr, door_tc;

  // Timers only run in their own state and are parked at 0 elsewhere;
  // under stop neither clears nor advances.
  assign trav_en  = !i_stop && (state_q == MOVE);
  assign trav_clr = !i_stop && (state_q != MOVE);
  assign door_en  = !i_stop && (state_q == DOOR);
  assign door_clr = !i_stop && ((state_q != DOOR) || i_door_hold);

  lift_timer #(.MAX(TRAVEL_CYCLES)) u_travel (
    .clk_i(i_clock), .rst_i(i_rst), .clr_i(trav_clr), .en_i(trav_en), .tc_o(trav_tc)
  );

  lift_timer #(.MAX(DOOR_CYCLES)) u_door (
    .clk_i(i_clock), .rst_i(i_rst), .clr_i(door_clr), .en_i(door_en), .tc_o(door_tc)
  );

  assign floor_step = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state_q  <= IDLE;
      floor_q  <= FLOOR_W'(RESET_FLOOR);
      target_q <= '0;
      dir_up_q <= 1'b1;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!i_stop) begin
        unique case (state_q)
          IDLE: if (!i_fifo_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
          FETCH: begin
            state_q <= LATCH;
            rd_en_q <= 1'b0;
          end
          LATCH: begin
            target_q <= i_rd_data;
            if ({1'b0, i_rd_data} >= NF_L) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (i_rd_data == floor_q) begin
              state_q <= DOOR;
              door_q  <= 1'b1;
            end else begin
              state_q  <= MOVE;
              moving_q <= 1'b1;
              dir_up_q <= (i_rd_data > floor_q);
            end
          end
          MOVE: if (trav_tc) begin
            floor_q <= floor_step;
            if (floor_step == target_q) begin
              state_q  <= DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
            end
          end
          DOOR: if (door_tc) begin
            state_q <= IDLE;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Stop must suppress a pop and motion in the very cycle it is raised,
  // otherwise a held FETCH would pop twice.
  assign o_rd_en     = rd_en_q && !i_stop;
  assign o_moving    = moving_q && !i_stop;
  assign o_floor     = floor_q;
  assign o_dir_up    = dir_up_q;
  assign o_door_open = door_q;
  assign o_busy      = busy_q;
  assign o_req_err   = err_q;
endmodule

// File: tb/tb_lift_ctrl.sv
module tb_lift_ctrl;
  localparam int NF = 8, TC = 4, DC = 3;

  logic       clk = 1'b0;
  logic       rst, fifo_empty, stop, hold;
  logic [3:0] rd_data;
  logic       rd_en, dir_up, moving, door_open, busy, req_err;
  logic [3:0] floor;

  lift_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .RESET_FLOOR(0)) dut (
    .i_clock(clk), .i_rst(rst), .i_rd_data(rd_data), .i_fifo_empty(fifo_empty),
    .o_rd_en(rd_en), .i_stop(stop), .i_door_hold(hold), .o_floor(floor),
    .o_dir_up(dir_up), .o_moving(moving), .o_door_open(door_open),
    .o_busy(busy), .o_req_err(req_err)
  );

  always #5 clk = ~clk;

  int         checks = 0, errors = 0, pop_cnt = 0;
  logic [3:0] fifo[$];
  int         model_floor = 0;
  bit         model_up = 1'b1;

  // One clock: a pop seen before the edge delivers FIFO head as read data after it.
  task automatic step();
    bit pop_now;
    #2;
    pop_now = (rd_en === 1'b1);
    @(posedge clk); #1;
    if (pop_now) begin
      pop_cnt++;
      if (fifo.size() > 0) rd_data = fifo.pop_front();
    end
    fifo_empty = (fifo.size() == 0);
  endtask

  // Serve one request from idle; expectations come from travel distance and the timing rules.
  task automatic do_request(input logic [3:0] r, input int stop_off, input int stop_len,
                            input int hold_off, input int hold_len, input string tag);
    int f0, d, t, n_mv, n_dr, n_err, first_rd, first_act, door_start, k, prev, pops0, shift;
    int exp_door;
    bit valid, done;
    f0 = model_floor; valid = (int'(r) < NF);
    d  = !valid ? 0 : (int'(r) > f0 ? int'(r) - f0 : f0 - int'(r));
    shift = (valid && d > 0) ? stop_len : 0;
    exp_door = valid ? DC + ((hold_len > 0) ? hold_off + hold_len : 0) : 0;
    n_mv = 0; n_dr = 0; n_err = 0; first_rd = -1; first_act = -1; door_start = -1;
    k = 0; prev = int'(floor); pops0 = pop_cnt; done = 0; t = 0;
    fifo.push_back(r); fifo_empty = 1'b0;
    while (t < 400 && !done) begin
      stop = (shift > 0) && (t >= 3 + stop_off) && (t < 3 + stop_off + stop_len);
      hold = (door_start >= 0) && (hold_len > 0) && (t >= door_start + hold_off) &&
             (t < door_start + hold_off + hold_len);
      step(); t++;
      if (rd_en && first_rd < 0) first_rd = t;
      if (moving) n_mv++;
      if (door_open) begin n_dr++; if (door_start < 0) door_start = t; end
      if (req_err) n_err++;
      if ((moving || door_open || req_err) && first_act < 0) first_act = t;
      if (int'(floor) != prev) begin
        k++;
        checks++;
        if (t != 3 + k * TC + shift || int'(floor) != (int'(r) > f0 ? f0 + k : f0 - k)) begin
          errors++;
          $display("FAIL %s floor_step%0d: got floor %0d at cycle %0d, exp floor %0d at cycle %0d",
                   tag, k, floor, t, (int'(r) > f0 ? f0 + k : f0 - k), 3 + k * TC + shift);
        end
        prev = int'(floor);
      end
      if (t > 1 && !busy) done = 1;
    end
    stop = 0; hold = 0;
    if (valid) model_floor = int'(r);
    if (valid && int'(r) > f0) model_up = 1'b1;
    if (valid && int'(r) < f0) model_up = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL %s timeout: got busy after %0d cycles, exp idle", tag, t); end
    checks++; if (pop_cnt - pops0 != 1) begin errors++; $display("FAIL %s pops: got %0d exp 1", tag, pop_cnt - pops0); end
    checks++; if (first_rd != 1) begin errors++; $display("FAIL %s rd_latency: got %0d exp 1", tag, first_rd); end
    checks++; if (first_act != 3) begin errors++; $display("FAIL %s act_latency: got %0d exp 3", tag, first_act); end
    checks++; if (n_mv != d * TC) begin errors++; $display("FAIL %s moving_cycles: got %0d exp %0d", tag, n_mv, d * TC); end
    checks++; if (n_dr != exp_door) begin errors++; $display("FAIL %s door_cycles: got %0d exp %0d", tag, n_dr, exp_door); end
    checks++; if (n_err != (valid ? 0 : 1)) begin errors++; $display("FAIL %s req_err: got %0d exp %0d", tag, n_err, valid ? 0 : 1); end
    checks++; if (k != d) begin errors++; $display("FAIL %s floor_changes: got %0d exp %0d", tag, k, d); end
    if (valid) begin
      checks++;
      if (door_start != 3 + d * TC + shift) begin
        errors++; $display("FAIL %s door_start: got %0d exp %0d", tag, door_start, 3 + d * TC + shift);
      end
    end
    checks++; if (int'(floor) != model_floor) begin errors++; $display("FAIL %s final_floor: got %0d exp %0d", tag, floor, model_floor); end
    checks++; if (dir_up !== model_up) begin errors++; $display("FAIL %s dir_up: got %0b exp %0b", tag, dir_up, model_up); end
  endtask

  task automatic test_reset();
    int n_rd;
    rst = 1; stop = 1; hold = 0; fifo_empty = 1; rd_data = '0;
    repeat (3) step();
    checks++;
    if (floor !== 4'd0 || dir_up !== 1'b1 || moving !== 1'b0 || door_open !== 1'b0 ||
        busy !== 1'b0 || req_err !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got floor=%0d up=%0b mv=%0b door=%0b busy=%0b err=%0b rd=%0b exp 0,1,0,0,0,0,0",
               floor, dir_up, moving, door_open, busy, req_err, rd_en);
    end
    rst = 0; n_rd = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) stop = 0;
      step();
      if (rd_en || busy) n_rd++;
    end
    checks++; if (n_rd != 0) begin errors++; $display("FAIL idle_empty: got %0d active cycles exp 0", n_rd); end
  endtask

  task automatic test_back_to_back();
    int t, n_rd, rd2, n_mv, pops0, d1, d2;
    d1 = (model_floor > 6) ? model_floor - 6 : 6 - model_floor; d2 = 4;
    pops0 = pop_cnt; n_rd = 0; rd2 = -1; n_mv = 0; t = 0;
    fifo.push_back(4'd6); fifo.push_back(4'd2); fifo_empty = 0;
    while (t < 400 && !(t > 5 && !busy && n_rd == 2)) begin
      step(); t++;
      if (rd_en) begin n_rd++; if (n_rd == 2) rd2 = t; end
      if (moving) n_mv++;
    end
    model_floor = 2; model_up = 1'b0;
    checks++; if (pop_cnt - pops0 != 2) begin errors++; $display("FAIL b2b pops: got %0d exp 2", pop_cnt - pops0); end
    checks++; if (rd2 != 3 + d1 * TC + DC + 1) begin errors++; $display("FAIL b2b second_pop: got %0d exp %0d", rd2, 3 + d1 * TC + DC + 1); end
    checks++; if (n_mv != (d1 + d2) * TC) begin errors++; $display("FAIL b2b moving: got %0d exp %0d", n_mv, (d1 + d2) * TC); end
    checks++; if (int'(floor) != 2 || dir_up !== 1'b0) begin errors++; $display("FAIL b2b final: got floor %0d up %0b exp 2 0", floor, dir_up); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int so, sl, ho, hl;
    for (int i = 0; i < 14; i++) begin
      r  = 4'($urandom_range(0, 9));
      so = $urandom_range(0, TC - 1); sl = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : 0;
      ho = $urandom_range(0, DC - 1); hl = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 4) : 0;
      do_request(r, so, sl, ho, hl, $sformatf("rand%0d_r%0d", i, r));
    end
  endtask

  task automatic test_mid_move_reset();
    int pops0, n_act;
    logic [3:0] r;
    r = (model_floor < 4) ? 4'd7 : 4'd0;
    pops0 = pop_cnt;
    fifo.push_back(r); fifo_empty = 0;
    repeat (3 + TC + 2) step();
    rst = 1; step(); rst = 0;
    model_floor = 0; model_up = 1'b1;
    checks++;
    if (floor !== 4'd0 || busy !== 1'b0 || moving !== 1'b0 || dir_up !== 1'b1 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got floor=%0d busy=%0b mv=%0b up=%0b door=%0b exp 0,0,0,1,0",
               floor, busy, moving, dir_up, door_open);
    end
    n_act = 0;
    repeat (6) begin step(); if (rd_en || busy || moving) n_act++; end
    checks++; if (n_act != 0 || pop_cnt - pops0 != 1) begin
      errors++; $display("FAIL mid_reset_idle: got %0d active, %0d pops exp 0, 1", n_act, pop_cnt - pops0);
    end
  endtask

  initial begin
    test_reset();
    do_request(4'd3, 0, 0, 0, 0, "test_up");
    do_request(4'd1, 0, 0, 0, 0, "test_down");
    do_request(4'd1, 0, 0, 0, 0, "test_same_floor");
    do_request(4'd9, 0, 0, 0, 0, "test_req_err");
    do_request(4'd8, 0, 0, 0, 0, "test_req_err_edge");
    do_request(4'd7, 0, 0, 0, 0, "test_after_err");
    do_request(4'd4, 1, 5, 1, 2, "test_stop_hold");
    test_back_to_back();
    test_random();
    test_mid_move_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
